// File: rtl/regbank4x16.sv
// ---------------------------------------------------------------------------
// regbank4x16
//   Four-entry register bank with a one-hot demuxed write port, a single
//   registered read port (1-cycle latency, write-first bypass) and a clear
//   sequencer that sweeps every entry to CLR_VAL, one entry per cycle.
//
//   Optional feature (compile-time macro REGBANK4X16_WRCOUNT_EN):
//     defined   - wr_count counts accepted writes, saturating at 8'hFF;
//                 only rst clears it.
//     undefined - wr_count is tied to 8'h00 and has no counter flops.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   we       in   write enable (demuxed onto four entry load strobes)
//   waddr    in   [1:0] write entry select
//   wdata    in   [WIDTH-1:0] write data
//   re       in   read request
//   raddr    in   [1:0] read entry select
//   rdata    out  [WIDTH-1:0] registered read data
//   rvalid   out  one-cycle pulse marking a fresh read result
//   clr      in   start a clear sweep (level-sampled while idle)
//   busy     out  high while the clear sweep runs
//   wr_count out  [7:0] accepted-write counter
// ---------------------------------------------------------------------------
module regbank4x16 #(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [1:0]       raddr,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   input  logic             clr,
   output logic             busy,
   output logic [7:0]       wr_count
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR0 = 3'd1,
      CLR1 = 3'd2,
      CLR2 = 3'd3,
      CLR3 = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [3:0]       clr_ld;
   logic [3:0]       wr_ld;
   logic             wr_acc;
   logic [WIDTH-1:0] entry [4];

   // Writes are only accepted while the sweep is not running.
   assign wr_acc = we && (state_q == IDLE);

   // Demux stage: one-hot entry load strobes.
   always_comb begin
      wr_ld = '0;
      if (wr_acc) begin
         wr_ld[waddr] = 1'b1;
      end
   end

   // Clear sequencer: next state and per-entry clear strobe.
   always_comb begin
      state_nxt = state_q;
      clr_ld    = '0;
      unique case (state_q)
         IDLE: if (clr) state_nxt = CLR0;
         CLR0: begin clr_ld[0] = 1'b1; state_nxt = CLR1; end
         CLR1: begin clr_ld[1] = 1'b1; state_nxt = CLR2; end
         CLR2: begin clr_ld[2] = 1'b1; state_nxt = CLR3; end
         CLR3: begin clr_ld[3] = 1'b1; state_nxt = IDLE; end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         busy    <= (state_nxt != IDLE);
      end
   end

   // Storage: clear strobe and write strobe never coincide (writes are
   // blocked while sweeping), so the priority here is cosmetic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            entry[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (clr_ld[i]) begin
               entry[i] <= CLR_VAL;
            end else if (wr_ld[i]) begin
               entry[i] <= wdata;
            end
         end
      end
   end

   // Read port: write-first bypass only for an accepted write; CLR_VAL is
   // never forwarded, so reads during the sweep see the pre-edge contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) begin
            rdata <= wr_ld[raddr] ? wdata : entry[raddr];
         end
      end
   end

`ifdef REGBANK4X16_WRCOUNT_EN
   logic [7:0] wr_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_q <= 8'h00;
      end else if (wr_acc && (wr_cnt_q != 8'hFF)) begin
         wr_cnt_q <= wr_cnt_q + 8'h01;
      end
   end

   assign wr_count = wr_cnt_q;
`else
   assign wr_count = 8'h00;
`endif

endmodule

// File: tb/tb_regbank4x16.sv
module tb_regbank4x16;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        we    = 1'b0;
   logic [1:0]  waddr = 2'd0;
   logic [15:0] wdata = 16'h0000;
   logic        re    = 1'b0;
   logic [1:0]  raddr = 2'd0;
   logic        clr   = 1'b0;
   logic [15:0] rdata;
   logic        rvalid;
   logic        busy;
   logic [7:0]  wr_count;

   regbank4x16 dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re       (re),
      .raddr    (raddr),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .clr      (clr),
      .busy     (busy),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   // Reference model: contents array, sweep position (-1 = not sweeping).
   logic [15:0] m_mem [4];
   int          m_sweep;
   int          m_cnt;
   logic [15:0] m_rdata;
   logic        m_rvalid;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_count();
`ifdef REGBANK4X16_WRCOUNT_EN
      return m_cnt[7:0];
`else
      return 8'h00;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_mem[i] = 16'h0000;
      m_sweep  = -1;
      m_cnt    = 0;
      m_rdata  = 16'h0000;
      m_rvalid = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".rdata"},  rdata,           m_rdata);
      chk({tag, ".rvalid"}, {15'd0, rvalid}, {15'd0, m_rvalid});
      chk({tag, ".busy"},   {15'd0, busy},   {15'd0, (m_sweep >= 0)});
      chk({tag, ".wrcnt"},  {8'd0, wr_count}, {8'd0, exp_count()});
   endtask

   // One clock cycle: drive on the falling edge, update model at the rising
   // edge, check 1 time unit later.
   task automatic step(input string tag, input logic i_we, input logic [1:0] i_wa,
                       input logic [15:0] i_wd, input logic i_re,
                       input logic [1:0] i_ra, input logic i_clr);
      bit acc;
      @(negedge clk);
      rst = 1'b0; we = i_we; waddr = i_wa; wdata = i_wd;
      re = i_re; raddr = i_ra; clr = i_clr;
      @(posedge clk);
      acc = i_we && (m_sweep < 0);
      m_rvalid = i_re;
      if (i_re) m_rdata = (acc && (i_wa == i_ra)) ? i_wd : m_mem[i_ra];
      if (acc) begin
         m_mem[i_wa] = i_wd;
         if (m_cnt < 255) m_cnt++;
      end
      if (m_sweep >= 0) begin
         m_mem[m_sweep] = 16'h0000;
         m_sweep = (m_sweep == 3) ? -1 : m_sweep + 1;
      end else if (i_clr) begin
         m_sweep = 0;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic wr(input string tag, input logic [1:0] a, input logic [15:0] d);
      step(tag, 1'b1, a, d, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic rd(input string tag, input logic [1:0] a);
      step(tag, 1'b0, 2'd0, 16'h0000, 1'b1, a, 1'b0);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b0);
   endtask

   initial begin
      int bcnt;
      model_reset();

      // Reset state while rst is held.
      #2;
      check_outputs("reset");

      // Reads after reset return zero with 1-cycle rvalid.
      for (int a = 0; a < 4; a++) begin
         rd("rst_rd", 2'(a));
         chk("rst_rd_zero", rdata, 16'h0000);
      end
      idle("rvalid_drop");

      // Write / readback.
      wr("wr2", 2'd2, 16'hA5A5);
      wr("wr0", 2'd0, 16'h1234);
      rd("rd2", 2'd2);
      chk("rd2_const", rdata, 16'hA5A5);
      rd("rd0", 2'd0);
      chk("rd0_const", rdata, 16'h1234);
      rd("rd1", 2'd1);
      rd("rd3", 2'd3);
      idle("hold");

      // Write-first bypass.
      step("bypass", 1'b1, 2'd3, 16'hBEEF, 1'b1, 2'd3, 1'b0);
      chk("bypass_const", rdata, 16'hBEEF);

      // Clear sweep with dropped writes.
      for (int a = 0; a < 4; a++) wr("fill", 2'(a), 16'hFFFF);
      step("clr_go", 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b1);
      bcnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (!busy) break;
         bcnt++;
         step("sweep_we", 1'b1, 2'(k), 16'h7777, 1'b1, 2'(k), 1'b0);
      end
      chk("busy_len", 16'(bcnt), 16'd4);
      for (int a = 0; a < 4; a++) begin
         rd("post_clr", 2'(a));
         chk("post_clr_zero", rdata, 16'h0000);
      end

      // clr and we together in IDLE, then clr held through the sweep.
      step("clr_we", 1'b1, 2'd1, 16'h4242, 1'b1, 2'd1, 1'b1);
      for (int k = 0; k < 6; k++)
         step("clr_hold", 1'b1, 2'(k), 16'(16'h1000 + k), 1'b1, 2'(k), 1'b1);
      for (int k = 0; k < 6; k++) rd("clr_hold_rd", 2'(k));

      // Reset during CLR1.
      wr("pre_rst", 2'd2, 16'h5555);
      step("rst_go", 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b1);
      idle("rst_clr1");
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_async");
      wr("wr_after_rst", 2'd2, 16'hCAFE);
      rd("rd_after_rst", 2'd2);
      chk("rd_after_rst_const", rdata, 16'hCAFE);
      rd("rd_after_rst1", 2'd1);
      chk("rd_after_rst1_zero", rdata, 16'h0000);

      // Counter saturation, then a sweep must not disturb it.
      for (int k = 0; k < 300; k++) wr("cnt_wr", 2'($urandom_range(0, 3)), 16'($urandom));
`ifdef REGBANK4X16_WRCOUNT_EN
      chk("cnt_sat", {8'd0, wr_count}, 16'h00FF);
`else
      chk("cnt_off", {8'd0, wr_count}, 16'h0000);
`endif
      step("cnt_clr", 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b1);
      for (int k = 0; k < 5; k++) idle("cnt_sweep");
`ifdef REGBANK4X16_WRCOUNT_EN
      chk("cnt_after_clr", {8'd0, wr_count}, 16'h00FF);
`else
      chk("cnt_after_clr", {8'd0, wr_count}, 16'h0000);
`endif

      // Randomized traffic against the model.
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rand_rst");
      for (int k = 0; k < 500; k++) begin
         step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 19) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
